bus_read_write_logic: RTL and testbench

//  CPU-side front end of the 8259 PIC, directly upstream of the controller.

---
 rtl/pic_pkg.sv | 46 ++++
 rtl/pic_sync_chain.sv | 25 ++
 rtl/bus_read_write_logic.sv | 165 ++++++++++++++++
 tb/tb_bus_read_write_logic.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 CPU bus front end: FSM encoding, read
// register selects, command-word bit positions and the write decoder.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_ACTIVE = 2'd1,
        ST_COMMIT    = 2'd2,
        ST_RD_ACTIVE = 2'd3
    } bus_state_t;

    localparam logic READ_IRR = 1'b0;
    localparam logic READ_ISR = 1'b1;

    localparam int ICW1_SEL = 4;
    localparam int OCW3_SEL = 3;
    localparam int RR       = 1;
    localparam int RIS      = 0;

    typedef struct packed {
        logic icw1;
        logic icw2_4;
        logic ocw1;
        logic ocw2;
        logic ocw3;
    } strobe_t;

    // A0=1 cannot be told apart here (ICW2/3/4 vs OCW1); the controller's
    // own init state decides which one it is, so both strobes fire.
    function automatic strobe_t decode_write(input logic a0, input logic [7:0] d);
        strobe_t s;
        s = '0;
        if (a0) begin
            s.icw2_4 = 1'b1;
            s.ocw1   = 1'b1;
        end else if (d[ICW1_SEL]) begin
            s.icw1 = 1'b1;
        end else if (!d[OCW3_SEL]) begin
            s.ocw2 = 1'b1;
        end else begin
            s.ocw3 = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/pic_sync_chain.sv
// Multi-flop synchroniser for one asynchronous CPU control line.
// RESET_VALUE lets active-low strobes come out of reset inactive.
module pic_sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bus_read_write_logic.sv
// CPU-side front end of the 8259: synchronises the bus, commits write bytes
// as one-cycle ICW/OCW strobes and returns IRR/ISR/IMR on reads.
module bus_read_write_logic
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       chip_select_n,
    input  logic       read_enable_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] in_service_register,
    input  logic [7:0] interrupt_mask_register,
    output logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1_reset,
    output logic       write_initial_command_word_2_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic [7:0] data_bus_out,
    output logic       data_bus_out_enable
);

    logic       s_cs_n;
    logic       s_rd_n;
    logic       s_wr_n;
    logic       s_a0;
    logic [7:0] data_pipe [SYNC_STAGES];
    logic [7:0] s_data;

    bus_state_t state;
    bus_state_t next_state;

    logic [7:0] cap_data;
    logic       cap_a0;
    logic       commit_edge;
    logic       read_select;
    strobe_t    strobe_q;

    // Active-low controls reset to 1 so the FSM never sees a phantom access.
    pic_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(chip_select_n), .q(s_cs_n));
    pic_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_rd (
        .clk(clk), .rst_n(rst_n), .d(read_enable_n), .q(s_rd_n));
    pic_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_wr (
        .clk(clk), .rst_n(rst_n), .d(write_enable_n), .q(s_wr_n));
    pic_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_a0 (
        .clk(clk), .rst_n(rst_n), .d(address), .q(s_a0));

    // Data delayed by the same depth as the controls so each sample lines up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_pipe[i] <= 8'h00;
            end
        end else begin
            data_pipe[0] <= data_bus_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign s_data = data_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!s_cs_n && !s_wr_n) begin
                    next_state = ST_WR_ACTIVE;
                end else if (!s_cs_n && !s_rd_n) begin
                    next_state = ST_RD_ACTIVE;
                end
            end
            ST_WR_ACTIVE: begin
                if (s_wr_n || s_cs_n) begin
                    next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                next_state = ST_IDLE;
            end
            ST_RD_ACTIVE: begin
                if (s_rd_n || s_cs_n) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign commit_edge = (state == ST_WR_ACTIVE) && (next_state == ST_COMMIT);

    // Only samples taken while the write is still qualified are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_data <= 8'h00;
            cap_a0   <= 1'b0;
        end else if (next_state == ST_WR_ACTIVE) begin
            cap_data <= s_data;
            cap_a0   <= s_a0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q          <= '0;
            internal_data_bus <= 8'h00;
            read_select       <= READ_IRR;
        end else begin
            strobe_q <= commit_edge ? decode_write(cap_a0, cap_data) : '0;
            if (commit_edge) begin
                internal_data_bus <= cap_data;
                if (!cap_a0) begin
                    if (cap_data[ICW1_SEL]) begin
                        read_select <= READ_IRR;
                    end else if (cap_data[OCW3_SEL] && cap_data[RR]) begin
                        read_select <= cap_data[RIS];
                    end
                end
            end
        end
    end

    assign write_initial_command_word_1_reset = strobe_q.icw1;
    assign write_initial_command_word_2_4     = strobe_q.icw2_4;
    assign write_operation_control_word_1     = strobe_q.ocw1;
    assign write_operation_control_word_2     = strobe_q.ocw2;
    assign write_operation_control_word_3     = strobe_q.ocw3;

    // Read data is valid from the same edge the enable rises and is parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_bus_out <= 8'h00;
        end else if (next_state == ST_RD_ACTIVE) begin
            if (s_a0) begin
                data_bus_out <= interrupt_mask_register;
            end else if (read_select == READ_ISR) begin
                data_bus_out <= in_service_register;
            end else begin
                data_bus_out <= interrupt_request_register;
            end
        end else begin
            data_bus_out <= 8'h00;
        end
    end

    assign data_bus_out_enable = (state == ST_RD_ACTIVE);

endmodule

// File: tb/tb_bus_read_write_logic.sv
// Bench for bus_read_write_logic: table-driven directed writes/reads, corner
// sequences (CS-first termination, reset mid-write) and a randomized phase.
module tb_bus_read_write_logic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       chip_select_n;
    logic       read_enable_n;
    logic       write_enable_n;
    logic       address;
    logic [7:0] data_bus_in;
    logic [7:0] interrupt_request_register;
    logic [7:0] in_service_register;
    logic [7:0] interrupt_mask_register;
    logic [7:0] internal_data_bus;
    logic       write_initial_command_word_1_reset;
    logic       write_initial_command_word_2_4;
    logic       write_operation_control_word_1;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;
    logic [7:0] data_bus_out;
    logic       data_bus_out_enable;

    bus_read_write_logic #(.SYNC_STAGES(2)) dut (
        .clk                                (clk),
        .rst_n                              (rst_n),
        .chip_select_n                      (chip_select_n),
        .read_enable_n                      (read_enable_n),
        .write_enable_n                     (write_enable_n),
        .address                            (address),
        .data_bus_in                        (data_bus_in),
        .interrupt_request_register         (interrupt_request_register),
        .in_service_register                (in_service_register),
        .interrupt_mask_register            (interrupt_mask_register),
        .internal_data_bus                  (internal_data_bus),
        .write_initial_command_word_1_reset (write_initial_command_word_1_reset),
        .write_initial_command_word_2_4     (write_initial_command_word_2_4),
        .write_operation_control_word_1     (write_operation_control_word_1),
        .write_operation_control_word_2     (write_operation_control_word_2),
        .write_operation_control_word_3     (write_operation_control_word_3),
        .data_bus_out                       (data_bus_out),
        .data_bus_out_enable                (data_bus_out_enable)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // strobe order {icw1, icw2_4, ocw1, ocw2, ocw3}
    logic [4:0] strb;
    assign strb = {write_initial_command_word_1_reset, write_initial_command_word_2_4,
                   write_operation_control_word_1, write_operation_control_word_2,
                   write_operation_control_word_3};

    localparam logic [4:0] S_ICW1 = 5'b10000;
    localparam logic [4:0] S_A0   = 5'b01100;
    localparam logic [4:0] S_OCW2 = 5'b00010;
    localparam logic [4:0] S_OCW3 = 5'b00001;

    int n_cmp  = 0;
    int n_fail = 0;

    // scoreboard: {strobes, committed byte} per expected commit
    logic [12:0] exp_q[$];
    logic [4:0]  prev_strb = 5'b0;

    // reference model state: which status register an A0=0 read returns (1 = ISR)
    logic model_rs = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Command-word rules applied directly to the written byte.
    function automatic logic [4:0] model_write(input logic a0, input logic [7:0] d);
        if (a0) return S_A0;
        if (d[4]) begin
            model_rs = 1'b0;
            return S_ICW1;
        end
        if (d[4:3] == 2'b00) return S_OCW2;
        if (d[1]) model_rs = d[0];
        return S_OCW3;
    endfunction

    function automatic logic [7:0] model_read(input logic a0);
        if (a0) return interrupt_mask_register;
        return model_rs ? in_service_register : interrupt_request_register;
    endfunction

    // Every strobe cycle must match the next expected commit and never repeat.
    always @(negedge clk) begin
        if (rst_n && strb != 5'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {19'b0, strb, internal_data_bus}, 32'h0);
            end else begin
                check("strobe_event", {19'b0, strb, internal_data_bus}, {19'b0, exp_q.pop_front()});
            end
            check("strobe_not_back_to_back", {27'b0, prev_strb}, 32'h0);
        end
        prev_strb = strb;
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_write(input logic a0, input logic [7:0] d, input int low,
                             input logic rd_too, input logic [4:0] exp_s);
        logic [7:0] bus_before;
        exp_q.push_back({exp_s, d});
        @(negedge clk);
        bus_before     = internal_data_bus;
        address        = a0;
        data_bus_in    = d;
        chip_select_n  = 1'b0;
        write_enable_n = 1'b0;
        if (rd_too) read_enable_n = 1'b0;
        repeat (low) begin
            @(negedge clk);
            if (rd_too) check("rd_ignored_during_write", {31'b0, data_bus_out_enable}, 32'h0);
        end
        write_enable_n = 1'b1;
        chip_select_n  = 1'b1;
        read_enable_n  = 1'b1;
        // first edge samples WR_n high, strobe appears after the third edge
        repeat (2) begin
            @(negedge clk);
            check("no_early_strobe", {27'b0, strb}, 32'h0);
            check("bus_held_until_commit", {24'b0, internal_data_bus}, {24'b0, bus_before});
        end
        @(negedge clk);
        check("strobe_latency", {27'b0, strb}, {27'b0, exp_s});
        check("bus_commit", {24'b0, internal_data_bus}, {24'b0, d});
        @(negedge clk);
        check("strobe_one_cycle", {27'b0, strb}, 32'h0);
        if (rd_too) check("no_read_after_write", {31'b0, data_bus_out_enable}, 32'h0);
    endtask

    task automatic cpu_read(input logic a0, input logic [7:0] exp_d);
        @(negedge clk);
        address       = a0;
        chip_select_n = 1'b0;
        read_enable_n = 1'b0;
        repeat (4) @(negedge clk);
        check("read_enable_high", {31'b0, data_bus_out_enable}, 32'h1);
        check("read_data", {24'b0, data_bus_out}, {24'b0, exp_d});
        read_enable_n = 1'b1;
        chip_select_n = 1'b1;
        repeat (2) @(negedge clk);
        check("read_enable_held", {31'b0, data_bus_out_enable}, 32'h1);
        @(negedge clk);
        check("read_enable_drop", {31'b0, data_bus_out_enable}, 32'h0);
    endtask

    typedef struct {
        logic       do_write;
        logic       a0;
        logic [7:0] d;
        int         low;
        logic       rd_too;
        logic [4:0] exp_s;
        logic       do_read;
        logic       rd_a0;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [4:0] e;
        logic       ra0;

        // ---------------- reset ----------------
        rst_n          = 1'b0;
        chip_select_n  = 1'b1;
        read_enable_n  = 1'b1;
        write_enable_n = 1'b1;
        address        = 1'b0;
        data_bus_in    = 8'h00;
        interrupt_request_register = 8'h81;
        in_service_register        = 8'h44;
        interrupt_mask_register    = 8'hF0;
        repeat (3) @(negedge clk);
        check("reset_strobes", {27'b0, strb}, 32'h0);
        check("reset_bus", {24'b0, internal_data_bus}, 32'h0);
        check("reset_dout", {24'b0, data_bus_out}, 32'h0);
        check("reset_enable", {31'b0, data_bus_out_enable}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- directed table ----------------
        vecs[0] = '{1'b1, 1'b0, 8'h13, 5, 1'b0, S_ICW1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'h20, 4, 1'b0, S_A0,   1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h0B, 4, 1'b0, S_OCW3, 1'b1, 1'b0, 8'h44};
        vecs[3] = '{1'b1, 1'b0, 8'h1B, 4, 1'b0, S_ICW1, 1'b1, 1'b0, 8'h81};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 5'b0,   1'b1, 1'b1, 8'hF0};
        vecs[5] = '{1'b1, 1'b0, 8'h20, 4, 1'b1, S_OCW2, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 8'h0A, 3, 1'b0, S_OCW3, 1'b1, 1'b0, 8'h81};
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_write) begin
                e = model_write(vecs[i].a0, vecs[i].d);
                cpu_write(vecs[i].a0, vecs[i].d, vecs[i].low, vecs[i].rd_too, vecs[i].exp_s);
            end
            if (vecs[i].do_read) cpu_read(vecs[i].rd_a0, vecs[i].exp_rd);
        end

        // ---------------- CS_n rises first; data changes while WR_n low ----------------
        exp_q.push_back({S_OCW3, 8'h0B});
        @(negedge clk);
        address = 1'b0; data_bus_in = 8'h55; chip_select_n = 1'b0; write_enable_n = 1'b0;
        repeat (2) @(negedge clk);
        data_bus_in = 8'h0B;
        repeat (2) @(negedge clk);
        chip_select_n = 1'b1;
        data_bus_in   = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            check("cs_end_no_early_strobe", {27'b0, strb}, 32'h0);
        end
        @(negedge clk);
        check("cs_end_strobe", {27'b0, strb}, {27'b0, S_OCW3});
        check("cs_end_bus", {24'b0, internal_data_bus}, 32'h0B);
        write_enable_n = 1'b1;
        e = model_write(1'b0, 8'h0B);
        repeat (3) @(negedge clk);
        cpu_read(1'b0, model_read(1'b0));

        // ---------------- reset in the middle of a write ----------------
        @(negedge clk);
        address = 1'b0; data_bus_in = 8'h13; chip_select_n = 1'b0; write_enable_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        chip_select_n  = 1'b1;
        write_enable_n = 1'b1;
        #1;
        check("midreset_strobes", {27'b0, strb}, 32'h0);
        check("midreset_bus", {24'b0, internal_data_bus}, 32'h0);
        check("midreset_enable", {31'b0, data_bus_out_enable}, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        model_rs = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_strobe_after_reset", {27'b0, strb}, 32'h0);
        end
        e = model_write(1'b0, 8'h08);
        cpu_write(1'b0, 8'h08, 4, 1'b0, S_OCW3);
        cpu_read(1'b0, 8'h81);

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 40; i++) begin
            logic       a0;
            logic [7:0] d;
            interrupt_request_register = 8'($urandom_range(0, 255));
            in_service_register        = 8'($urandom_range(0, 255));
            interrupt_mask_register    = 8'($urandom_range(0, 255));
            a0 = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            e  = model_write(a0, d);
            cpu_write(a0, d, $urandom_range(3, 6), 1'($urandom_range(0, 1)), e);
            if ($urandom_range(0, 1) == 1) begin
                ra0 = 1'($urandom_range(0, 1));
                cpu_read(ra0, model_read(ra0));
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
